// File: rtl/mem_pkg.sv
// Shared types and constants for the 32-bit to 16-bit SRAM memory-stage controller.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam int ADDR_BASE_DEFAULT = 1024;
    localparam int WORD_W            = 32;
    localparam int HALF_W            = 16;
endpackage

// File: rtl/sram_phase_timer.sv
// Per-phase cycle timer: counts a WAIT_CYCLES phase and produces a registered write strobe
// that drops one cycle before the phase ends, leaving a data-hold cycle.
module sram_phase_timer #(
    parameter int WAIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    input  logic strobe_en,
    output logic last,
    output logic strobe_active
);
    localparam int CW = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(WAIT_CYCLES - 2);

    logic [CW-1:0] cnt;

    assign last = (cnt == CNT_LAST);

    // Strobe is registered so the SRAM write pin is driven straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            strobe_active <= 1'b0;
        end else if (start) begin
            cnt           <= '0;
            strobe_active <= strobe_en;
        end else if (run) begin
            if (!last)
                cnt <= cnt + CW'(1);
            strobe_active <= strobe_active && (cnt != CNT_PRE);
        end else begin
            strobe_active <= 1'b0;
        end
    end
endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage word access to a 16-bit async SRAM as two half-word phases; ready low stalls the pipe.
// Optional MEM_SRAM_CTRL_STATS_EN adds saturating read/write/stall counters.
module mem_sram_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int WAIT_CYCLES = 4,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [WORD_W-1:0]  address,
    input  logic [WORD_W-1:0]  wdata,
    output logic [WORD_W-1:0]  rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [HALF_W-1:0]  sram_dq_o,
    input  logic [HALF_W-1:0]  sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n
`ifdef MEM_SRAM_CTRL_STATS_EN
    ,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count,
    output logic [31:0]        stall_count
`endif
);
    state_t             state, state_nxt;
    logic               op_wr, op_wr_nxt;
    logic [SRAM_AW-2:0] waddr, waddr_nxt;
    logic [WORD_W-1:0]  wdata_q, wdata_nxt;
    logic               req, enter_lo, enter_hi, phase_start, phase_run;
    logic               last, strobe_active;

    assign req   = rd_en | wr_en;
    assign ready = ~req | (state == DONE);

    always_comb begin
        state_nxt = state;
        op_wr_nxt = op_wr;
        waddr_nxt = waddr;
        wdata_nxt = wdata_q;
        case (state)
            IDLE: if (req) begin
                state_nxt = LO;
                op_wr_nxt = wr_en;
                // Word index truncated to the SRAM size, so out-of-range addresses wrap.
                waddr_nxt = (SRAM_AW-1)'((address - WORD_W'(ADDR_BASE)) >> 2);
                wdata_nxt = wdata;
            end
            LO:      if (last) state_nxt = HI;
            HI:      if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_lo    = (state_nxt == LO) && (state != LO);
    assign enter_hi    = (state_nxt == HI) && (state != HI);
    assign phase_start = enter_lo | enter_hi;
    assign phase_run   = (state == LO) || (state == HI);

    sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
        .clk           (clk),
        .rst           (rst),
        .start         (phase_start),
        .run           (phase_run),
        .strobe_en     (op_wr_nxt),
        .last          (last),
        .strobe_active (strobe_active)
    );

    assign sram_we_n = ~strobe_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_wr      <= 1'b0;
            waddr      <= '0;
            wdata_q    <= '0;
            rdata      <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
        end else begin
            state      <= state_nxt;
            op_wr      <= op_wr_nxt;
            waddr      <= waddr_nxt;
            wdata_q    <= wdata_nxt;
            sram_dq_oe <= ((state_nxt == LO) || (state_nxt == HI)) && op_wr_nxt;
            if (enter_lo) begin
                sram_addr <= {waddr_nxt, 1'b0};
                if (op_wr_nxt)
                    sram_dq_o <= wdata_nxt[HALF_W-1:0];
            end else if (enter_hi) begin
                sram_addr <= {waddr, 1'b1};
                if (op_wr)
                    sram_dq_o <= wdata_q[WORD_W-1:HALF_W];
            end
            // Async SRAM data is taken on the final cycle of each read phase.
            if (!op_wr && last && (state == LO))
                rdata[HALF_W-1:0] <= sram_dq_i;
            if (!op_wr && last && (state == HI))
                rdata[WORD_W-1:HALF_W] <= sram_dq_i;
        end
    end

`ifdef MEM_SRAM_CTRL_STATS_EN
    logic enter_done;
    assign enter_done = (state == HI) && (state_nxt == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count    <= '0;
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            if (enter_done && !op_wr && (rd_count != 32'hFFFF_FFFF))
                rd_count <= rd_count + 32'd1;
            if (enter_done && op_wr && (wr_count != 32'hFFFF_FFFF))
                wr_count <= wr_count + 32'd1;
            if (!ready && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl with a 256-entry async SRAM model (WAIT_CYCLES=4).
module tb_mem_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_we_n;
`ifdef MEM_SRAM_CTRL_STATS_EN
    logic [31:0] rd_count, wr_count, stall_count;
`endif

    mem_sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(4), .SRAM_AW(18)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
`ifdef MEM_SRAM_CTRL_STATS_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    logic [15:0] ref_mem [0:255];
    always @(posedge clk)
        if (!sram_we_n && sram_dq_oe)
            mem[sram_addr[7:0]] <= sram_dq_o;
    assign sram_dq_i = mem[sram_addr[7:0]];

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    logic [17:0] tr_addr [0:63];
    logic [15:0] tr_dq   [0:63];
    logic        tr_we   [0:63];
    logic        tr_oe   [0:63];

    // Drives one request from posedge+1 and samples every negedge until ready; n=99 on timeout.
    task automatic run_access(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, output int n);
        wr_en = w; rd_en = r; address = a; wdata = d;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            tr_addr[n] = sram_addr; tr_dq[n] = sram_dq_o;
            tr_we[n] = sram_we_n;   tr_oe[n] = sram_dq_oe;
            n++;
            if (ready) break;
        end
        if (!ready) n = 99;
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
        total++; if ({sram_addr, sram_dq_o} !== 34'h0) begin bad++; $display("FAIL reset_sram got %h/%h want 0/0", sram_addr, sram_dq_o); end
        total++; if ({ready, sram_we_n, sram_dq_oe} !== 3'b110) begin bad++; $display("FAIL reset_ctl got %b want 110", {ready, sram_we_n, sram_dq_oe}); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_idle;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++;
            if ({ready, sram_we_n, sram_dq_oe} !== 3'b110) begin
                bad++; $display("FAIL idle_ctl cycle %0d got %b want 110", c, {ready, sram_we_n, sram_dq_oe});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        int n;
        logic [31:0] d;
        logic [31:0] e;
        d = 32'hDEAD_BEEF;
        run_access(1, 0, 32'd1028, d, n);
        ref_mem[2] = d[15:0]; ref_mem[3] = d[31:16];
        total++; if (n !== 10) begin bad++; $display("FAIL wr_latency got %0d want 10", n); end
        total++; if ({tr_we[0], tr_oe[0], tr_we[9], tr_oe[9]} !== 4'b1010) begin
            bad++; $display("FAIL wr_edges got %b want 1010", {tr_we[0], tr_oe[0], tr_we[9], tr_oe[9]});
        end
        for (int i = 1; i <= 8; i++) begin
            int p, k;
            p = (i - 1) / 4; k = (i - 1) % 4;
            total++;
            if (tr_addr[i] !== 18'(2 + p) || tr_dq[i] !== (p ? d[31:16] : d[15:0]) ||
                tr_we[i] !== (k == 3) || tr_oe[i] !== 1'b1) begin
                bad++; $display("FAIL wr_phase cyc %0d got a=%0d dq=%h we=%b oe=%b want a=%0d dq=%h we=%b oe=1",
                                i, tr_addr[i], tr_dq[i], tr_we[i], tr_oe[i], 2 + p, (p ? d[31:16] : d[15:0]), (k == 3));
            end
        end
        exp_q.push_back({ref_mem[3], ref_mem[2]});
        run_access(0, 1, 32'd1028, 32'h0, n);
        total++; if (n !== 10) begin bad++; $display("FAIL rd_latency got %0d want 10", n); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({tr_we[i], tr_oe[i]} !== 2'b10) begin
                bad++; $display("FAIL rd_strobes cyc %0d got %b want 10", i, {tr_we[i], tr_oe[i]});
            end
        end
        e = exp_q.pop_front();
        total++; if (rdata !== e) begin bad++; $display("FAIL rd_data got %h want %h", rdata, e); end
        last_rd = e;
    endtask

    task automatic test_back_to_back;
        int n1, n2;
        logic [31:0] e;
        exp_q.push_back({ref_mem[1], ref_mem[0]});
        run_access(0, 1, 32'd1024, 32'h0, n1);
        e = exp_q.pop_front();
        total++; if (rdata !== e) begin bad++; $display("FAIL b2b_data0 got %h want %h", rdata, e); end
        total++; if (tr_addr[2] !== 18'd0 || tr_addr[6] !== 18'd1) begin
            bad++; $display("FAIL b2b_addr0 got %0d,%0d want 0,1", tr_addr[2], tr_addr[6]);
        end
        exp_q.push_back({ref_mem[5], ref_mem[4]});
        run_access(0, 1, 32'd1032, 32'h0, n2);
        total++; if (n1 !== 10 || n2 !== 10) begin bad++; $display("FAIL b2b_latency got %0d,%0d want 10,10", n1, n2); end
        total++; if (tr_addr[2] !== 18'd4 || tr_addr[6] !== 18'd5) begin
            bad++; $display("FAIL b2b_addr1 got %0d,%0d want 4,5", tr_addr[2], tr_addr[6]);
        end
        e = exp_q.pop_front();
        total++; if (rdata !== e) begin bad++; $display("FAIL b2b_data1 got %h want %h", rdata, e); end
        last_rd = e;
    endtask

    task automatic test_both_high;
        int n;
        logic [31:0] e;
        run_access(1, 1, 32'd1040, 32'h1234_5678, n);
        ref_mem[8] = 16'h5678; ref_mem[9] = 16'h1234;
        total++; if (n !== 10 || tr_oe[1] !== 1'b1 || tr_we[1] !== 1'b0) begin
            bad++; $display("FAIL both_write got n=%0d oe=%b we=%b want 10/1/0", n, tr_oe[1], tr_we[1]);
        end
        total++; if (rdata !== last_rd) begin bad++; $display("FAIL both_rdata got %h want %h", rdata, last_rd); end
        exp_q.push_back({ref_mem[9], ref_mem[8]});
        run_access(0, 1, 32'd1040, 32'h0, n);
        e = exp_q.pop_front();
        total++; if (rdata !== e) begin bad++; $display("FAIL both_readback got %h want %h", rdata, e); end
    endtask

    task automatic test_reset_mid_write;
        int n;
        logic [31:0] e;
        wr_en = 1; address = 32'd1048; wdata = 32'hCAFE_F00D;
        repeat (5) @(posedge clk);
        #1;
        total++; if (sram_addr !== 18'd13 || sram_we_n !== 1'b0) begin
            bad++; $display("FAIL rstmid_inhi got a=%0d we=%b want 13/0", sram_addr, sram_we_n);
        end
        rst = 1'b1;
        #1;
        total++; if ({sram_we_n, sram_dq_oe} !== 2'b10 || sram_addr !== 18'd0 || sram_dq_o !== 16'h0 || rdata !== 32'h0) begin
            bad++; $display("FAIL rstmid_outs got we=%b oe=%b a=%0d dq=%h rd=%h want 1/0/0/0/0",
                            sram_we_n, sram_dq_oe, sram_addr, sram_dq_o, rdata);
        end
        wr_en = 0;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got %b want 1", ready); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        ref_mem[12] = 16'hF00D;
        exp_q.push_back({ref_mem[13], ref_mem[12]});
        run_access(0, 1, 32'd1048, 32'h0, n);
        e = exp_q.pop_front();
        total++; if (rdata !== e) begin bad++; $display("FAIL rstmid_read got %h want %h", rdata, e); end
    endtask

`ifdef MEM_SRAM_CTRL_STATS_EN
    task automatic test_stats;
        int n;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_access(0, 1, 32'd1024, 32'h0, n);
        run_access(1, 0, 32'd1100, 32'h0BAD_F00D, n);
        total++; if ({rd_count, wr_count, stall_count} !== {32'd1, 32'd1, 32'd18}) begin
            bad++; $display("FAIL stats got rd=%0d wr=%0d stall=%0d want 1/1/18", rd_count, wr_count, stall_count);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'h5A00 | 16'(i);
            ref_mem[i] = 16'h5A00 | 16'(i);
        end
        last_rd = '0;
        test_reset;
        test_idle;
        test_write_read;
        test_back_to_back;
        test_both_high;
        test_reset_mid_write;
`ifdef MEM_SRAM_CTRL_STATS_EN
        test_stats;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
